// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the round-robin stream multiplexer: arbiter state
// encodings, index-width helpers and the channel-slice macro.
`ifndef STREAM_MUX_RR_PKG_SV
`define STREAM_MUX_RR_PKG_SV

// Part-select of channel idx inside a flat NCH*WIDTH bus.
`define SMR_CH(idx, w) (idx)*(w) +: (w)

package stream_mux_rr_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // A single channel still needs a 1-bit select field.
    function automatic int selw(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

`endif

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester found searching from
// ptr upward with wrap at NCH-1 (NCH need not be a power of two).
module rr_pick
    import stream_mux_rr_pkg::*;
#(
    parameter int NCH  = 4,
    parameter int SELW = selw(NCH)
) (
    input  logic [NCH-1:0]  req_i,
    input  logic [SELW-1:0] ptr_i,
    output logic [SELW-1:0] grant_o,
    output logic            gvalid_o
);

    always_comb begin
        int   idx;
        logic found;
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(ptr_i) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && req_i[idx]) begin
                found   = 1'b1;
                grant_o = SELW'(idx);
            end
        end
        gvalid_o = |req_i;
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with round-robin arbitration, optional
// per-packet grant locking and a single registered output stage.
module stream_mux_rr
    import stream_mux_rr_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NCH      = 4,
    parameter bit LOCK_PKT = 1'b1,
    parameter int SELW     = selw(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH-1:0]       in_last,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    output logic                 out_last,
    output logic [SELW-1:0]      out_sel,
    input  logic                 out_ready
);

    state_e            state_q;
    logic [SELW-1:0]   cur_q, ptr_q, ptr_d;
    logic [WIDTH-1:0]  data_q;
    logic              valid_q, last_q;
    logic [SELW-1:0]   sel_q;

    logic [SELW-1:0]   rr_grant, grant;
    logic              rr_gvalid, gvalid, load, xfer, beat_last;

    rr_pick #(.NCH(NCH), .SELW(SELW)) u_pick (
        .req_i    (in_valid),
        .ptr_i    (ptr_q),
        .grant_o  (rr_grant),
        .gvalid_o (rr_gvalid)
    );

    // While locked only the owning channel is eligible, even if it idles.
    always_comb begin
        grant  = rr_grant;
        gvalid = rr_gvalid;
        if (state_q == ST_LOCKED) begin
            grant  = cur_q;
            gvalid = in_valid[cur_q];
        end
    end

    assign load      = !valid_q || out_ready;
    assign xfer      = load && gvalid;
    assign beat_last = in_last[grant];
    assign ptr_d     = (int'(grant) == NCH - 1) ? '0 : grant + 1'b1;

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sel_q   <= '0;
        end else if (load) begin
            valid_q <= gvalid;
            if (gvalid) begin
                data_q <= in_data[`SMR_CH(grant, WIDTH)];
                last_q <= beat_last;
                sel_q  <= grant;
                if (!LOCK_PKT || beat_last) begin
                    state_q <= ST_IDLE;
                    ptr_q   <= ptr_d;
                end else begin
                    state_q <= ST_LOCKED;
                    cur_q   <= grant;
                end
            end
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_sel   = sel_q;

endmodule
